// File: rtl/pong_pkg.sv
// Shared types and default geometry for the pong engine.
// Game-state encoding, winner encoding and signed coordinate type.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_P1   = 2'd1,
        WIN_P2   = 2'd2
    } winner_e;

    // 11-bit signed so that x - r or y - r never wraps below zero
    typedef logic signed [10:0] coord_t;

    localparam int DEF_TICK_DIV     = 833333;
    localparam int DEF_FIELD_X0     = 240;
    localparam int DEF_FIELD_X1     = 400;
    localparam int DEF_FIELD_Y0     = 80;
    localparam int DEF_FIELD_Y1     = 450;
    localparam int DEF_P1X          = 220;
    localparam int DEF_P2X          = 400;
    localparam int DEF_PADDLE_W     = 20;
    localparam int DEF_PADDLE_H     = 80;
    localparam int DEF_BALL_R       = 7;
    localparam int DEF_BALL_SPEED   = 1;
    localparam int DEF_PADDLE_SPEED = 1;
    localparam int DEF_SERVE_TICKS  = 60;
    localparam int DEF_WIN_SCORE    = 11;

endpackage

// File: rtl/pong_tick_gen.sv
// Game-tick strobe: one-cycle pulse every DIV clocks, first pulse DIV clocks after reset.
// Latency: registered strobe; backpressure: none (free-running).
module pong_tick_gen #(
    parameter int DIV = 833333
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        tick_d = (cnt_q == CW'(DIV - 1));
        cnt_d  = tick_d ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/pong_game_engine.sv
// Pong game engine: paddles, ball physics, scoring and game FSM, updated once per game tick.
// Latency: all outputs registered, change one clock after the tick strobe; backpressure: none.
module pong_game_engine
    import pong_pkg::*;
#(
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int FIELD_X0     = DEF_FIELD_X0,
    parameter int FIELD_X1     = DEF_FIELD_X1,
    parameter int FIELD_Y0     = DEF_FIELD_Y0,
    parameter int FIELD_Y1     = DEF_FIELD_Y1,
    parameter int P1X          = DEF_P1X,
    parameter int P2X          = DEF_P2X,
    parameter int PADDLE_W     = DEF_PADDLE_W,
    parameter int PADDLE_H     = DEF_PADDLE_H,
    parameter int BALL_R       = DEF_BALL_R,
    parameter int BALL_SPEED   = DEF_BALL_SPEED,
    parameter int PADDLE_SPEED = DEF_PADDLE_SPEED,
    parameter int SERVE_TICKS  = DEF_SERVE_TICKS,
    parameter int WIN_SCORE    = DEF_WIN_SCORE
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic       i_run,
    input  logic       up1,
    input  logic       down1,
    input  logic       up2,
    input  logic       down2,
    output logic [9:0] o_ball_x,
    output logic [9:0] o_ball_y,
    output logic [9:0] o_p1y,
    output logic [9:0] o_p2y,
    output logic [3:0] o_p1score,
    output logic [3:0] o_p2score,
    output logic [2:0] o_state,
    output logic [1:0] o_winner,
    output logic       o_tick
);

    localparam coord_t FX0    = coord_t'(FIELD_X0);
    localparam coord_t FX1    = coord_t'(FIELD_X1);
    localparam coord_t FY0    = coord_t'(FIELD_Y0);
    localparam coord_t FY1    = coord_t'(FIELD_Y1);
    localparam coord_t P1R    = coord_t'(P1X + PADDLE_W);
    localparam coord_t P2L    = coord_t'(P2X);
    localparam coord_t PH     = coord_t'(PADDLE_H);
    localparam coord_t BR     = coord_t'(BALL_R);
    localparam coord_t BSPD   = coord_t'(BALL_SPEED);
    localparam coord_t PSPD   = coord_t'(PADDLE_SPEED);
    localparam coord_t PY_MIN = coord_t'(FIELD_Y0);
    localparam coord_t PY_MAX = coord_t'(FIELD_Y1 - PADDLE_H);

    localparam logic [9:0] CX    = 10'((FIELD_X0 + FIELD_X1) / 2);
    localparam logic [9:0] CY    = 10'((FIELD_Y0 + FIELD_Y1) / 2);
    localparam logic [9:0] PHOME = 10'((FIELD_Y0 + FIELD_Y1 - PADDLE_H) / 2);
    localparam logic [9:0] Y_TOP = 10'(FIELD_Y0 + BALL_R);
    localparam logic [9:0] Y_BOT = 10'(FIELD_Y1 - BALL_R);
    localparam logic [9:0] X_P1  = 10'(P1X + PADDLE_W + BALL_R);
    localparam logic [9:0] X_P2  = 10'(P2X - BALL_R);
    localparam logic [3:0] WIN   = 4'(WIN_SCORE);
    localparam int         SCW   = $clog2(SERVE_TICKS + 1);

    state_e         state_q, state_d;
    winner_e        winner_q, winner_d;
    logic [9:0]     ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic [9:0]     p1y_q, p1y_d, p2y_q, p2y_d;
    logic [3:0]     p1score_q, p1score_d, p2score_q, p2score_d;
    logic           dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
    logic           serve_dx_neg_q, serve_dx_neg_d, serve_dy_neg_q, serve_dy_neg_d;
    logic           p1_scored_q, p1_scored_d;
    logic [SCW-1:0] serve_cnt_q, serve_cnt_d;
    logic           tick;

    coord_t     bx, by, nx, ny, p1s, p2s;
    logic [3:0] new_score;

    pong_tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk   (iVGA_CLK),
        .rst_n (iRST_n),
        .tick  (tick)
    );

    function automatic logic [9:0] paddle_step(input logic [9:0] y, input logic up_n,
                                               input logic dn_n);
        coord_t ys;
        coord_t yn;
        ys = coord_t'({1'b0, y});
        yn = ys;
        if (!up_n && dn_n)
            yn = (ys - PSPD < PY_MIN) ? PY_MIN : ys - PSPD;
        else if (up_n && !dn_n)
            yn = (ys + PSPD > PY_MAX) ? PY_MAX : ys + PSPD;
        return yn[9:0];
    endfunction

    always_comb begin
        state_d        = state_q;
        winner_d       = winner_q;
        ball_x_d       = ball_x_q;
        ball_y_d       = ball_y_q;
        p1y_d          = p1y_q;
        p2y_d          = p2y_q;
        p1score_d      = p1score_q;
        p2score_d      = p2score_q;
        dx_neg_d       = dx_neg_q;
        dy_neg_d       = dy_neg_q;
        serve_dx_neg_d = serve_dx_neg_q;
        serve_dy_neg_d = serve_dy_neg_q;
        p1_scored_d    = p1_scored_q;
        serve_cnt_d    = serve_cnt_q;

        bx        = coord_t'({1'b0, ball_x_q});
        by        = coord_t'({1'b0, ball_y_q});
        p1s       = coord_t'({1'b0, p1y_q});
        p2s       = coord_t'({1'b0, p2y_q});
        nx        = dx_neg_q ? bx - BSPD : bx + BSPD;
        ny        = dy_neg_q ? by - BSPD : by + BSPD;
        new_score = p1_scored_q ? p1score_q + 4'd1 : p2score_q + 4'd1;

        if (!i_run) begin
            state_d        = ST_IDLE;
            winner_d       = WIN_NONE;
            ball_x_d       = CX;
            ball_y_d       = CY;
            p1y_d          = PHOME;
            p2y_d          = PHOME;
            p1score_d      = 4'd0;
            p2score_d      = 4'd0;
            dx_neg_d       = 1'b0;
            dy_neg_d       = 1'b0;
            serve_dx_neg_d = 1'b0;
            serve_dy_neg_d = 1'b0;
            p1_scored_d    = 1'b0;
            serve_cnt_d    = '0;
        end else if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    state_d     = ST_SERVE;
                    serve_cnt_d = '0;
                end
                ST_SERVE: begin
                    p1y_d    = paddle_step(p1y_q, up1, down1);
                    p2y_d    = paddle_step(p2y_q, up2, down2);
                    ball_x_d = CX;
                    ball_y_d = CY;
                    if (serve_cnt_q == SCW'(SERVE_TICKS - 1)) begin
                        state_d        = ST_PLAY;
                        dx_neg_d       = serve_dx_neg_q;
                        dy_neg_d       = serve_dy_neg_q;
                        serve_dy_neg_d = ~serve_dy_neg_q;
                    end else begin
                        serve_cnt_d = serve_cnt_q + 1'b1;
                    end
                end
                ST_PLAY: begin
                    p1y_d = paddle_step(p1y_q, up1, down1);
                    p2y_d = paddle_step(p2y_q, up2, down2);
                    // Y and X are resolved independently so a corner hit flips both
                    if (ny - BR <= FY0) begin
                        ball_y_d = Y_TOP;
                        dy_neg_d = 1'b0;
                    end else if (ny + BR >= FY1) begin
                        ball_y_d = Y_BOT;
                        dy_neg_d = 1'b1;
                    end else begin
                        ball_y_d = ny[9:0];
                    end
                    if (dx_neg_q && (nx - BR <= P1R) && (p1s <= ny) && (ny <= p1s + PH)) begin
                        ball_x_d = X_P1;
                        dx_neg_d = 1'b0;
                    end else if (!dx_neg_q && (nx + BR >= P2L) && (p2s <= ny)
                                 && (ny <= p2s + PH)) begin
                        ball_x_d = X_P2;
                        dx_neg_d = 1'b1;
                    end else if (nx - BR <= FX0) begin
                        state_d     = ST_POINT;
                        p1_scored_d = 1'b0;
                    end else if (nx + BR >= FX1) begin
                        state_d     = ST_POINT;
                        p1_scored_d = 1'b1;
                    end else begin
                        ball_x_d = nx[9:0];
                    end
                end
                ST_POINT: begin
                    ball_x_d    = CX;
                    ball_y_d    = CY;
                    serve_cnt_d = '0;
                    // next serve heads toward the player who just lost the point
                    serve_dx_neg_d = ~p1_scored_q;
                    if (p1_scored_q) p1score_d = new_score;
                    else             p2score_d = new_score;
                    if (new_score == WIN) begin
                        state_d  = ST_OVER;
                        winner_d = p1_scored_q ? WIN_P1 : WIN_P2;
                    end else begin
                        state_d = ST_SERVE;
                    end
                end
                ST_OVER: state_d = ST_OVER;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q        <= ST_IDLE;
            winner_q       <= WIN_NONE;
            ball_x_q       <= CX;
            ball_y_q       <= CY;
            p1y_q          <= PHOME;
            p2y_q          <= PHOME;
            p1score_q      <= 4'd0;
            p2score_q      <= 4'd0;
            dx_neg_q       <= 1'b0;
            dy_neg_q       <= 1'b0;
            serve_dx_neg_q <= 1'b0;
            serve_dy_neg_q <= 1'b0;
            p1_scored_q    <= 1'b0;
            serve_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            winner_q       <= winner_d;
            ball_x_q       <= ball_x_d;
            ball_y_q       <= ball_y_d;
            p1y_q          <= p1y_d;
            p2y_q          <= p2y_d;
            p1score_q      <= p1score_d;
            p2score_q      <= p2score_d;
            dx_neg_q       <= dx_neg_d;
            dy_neg_q       <= dy_neg_d;
            serve_dx_neg_q <= serve_dx_neg_d;
            serve_dy_neg_q <= serve_dy_neg_d;
            p1_scored_q    <= p1_scored_d;
            serve_cnt_q    <= serve_cnt_d;
        end
    end

    assign o_ball_x  = ball_x_q;
    assign o_ball_y  = ball_y_q;
    assign o_p1y     = p1y_q;
    assign o_p2y     = p2y_q;
    assign o_p1score = p1score_q;
    assign o_p2score = p2score_q;
    assign o_state   = state_q;
    assign o_winner  = winner_q;
    assign o_tick    = tick;

endmodule

// File: tb/tb_pong_game_engine.sv
// Directed bench for pong_game_engine with TICK_DIV=4, SERVE_TICKS=2.
// Trajectories below are worked out by hand from the centre serve (320,265).
module tb_pong_game_engine;

    logic       clk;
    logic       rst_n;
    logic       i_run;
    logic       up1, down1, up2, down2;
    logic [9:0] o_ball_x, o_ball_y, o_p1y, o_p2y;
    logic [3:0] o_p1score, o_p2score;
    logic [2:0] o_state;
    logic [1:0] o_winner;
    logic       o_tick;

    int n_tests;
    int n_fail;
    int tk;

    pong_game_engine #(
        .TICK_DIV    (4),
        .SERVE_TICKS (2)
    ) dut (
        .iVGA_CLK  (clk),
        .iRST_n    (rst_n),
        .i_run     (i_run),
        .up1       (up1),
        .down1     (down1),
        .up2       (up2),
        .down2     (down2),
        .o_ball_x  (o_ball_x),
        .o_ball_y  (o_ball_y),
        .o_p1y     (o_p1y),
        .o_p2y     (o_p2y),
        .o_p1score (o_p1score),
        .o_p2score (o_p2score),
        .o_state   (o_state),
        .o_winner  (o_winner),
        .o_tick    (o_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Wait for the strobe, then for the edge that applies the update; sample 1 time unit later.
    task automatic next_tick();
        int n;
        n = 0;
        while (o_tick !== 1'b1 && n < 16) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (o_tick !== 1'b1) check("tick_timeout", int'(o_tick), 1);
        @(posedge clk);
        #1;
        tk++;
    endtask

    task automatic run_to(input int t);
        while (tk < t) next_tick();
    endtask

    task automatic latency_check(input string tag);
        int first;
        first = 0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            if (o_tick === 1'b1 && first == 0) first = c;
        end
        check(tag, first, 4);
    endtask

    task automatic drop_run();
        i_run = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; i_run = 1'b0;
        up1 = 1'b1; down1 = 1'b1; up2 = 1'b1; down2 = 1'b1;
        n_tests = 0; n_fail = 0; tk = 0;

        // reset state
        #12;
        check("rst_state", int'(o_state), 0);
        check("rst_ball_x", int'(o_ball_x), 320);
        check("rst_ball_y", int'(o_ball_y), 265);
        check("rst_p1y", int'(o_p1y), 225);
        check("rst_p2y", int'(o_p2y), 225);
        check("rst_scores", int'(o_p1score) + int'(o_p2score), 0);
        check("rst_winner", int'(o_winner), 0);
        check("rst_tick", int'(o_tick), 0);
        @(negedge clk) rst_n = 1'b1;
        latency_check("first_tick_latency");

        // paddle saturation: P1 up, P2 down
        i_run = 1'b1; up1 = 1'b0; down2 = 1'b0; tk = 0;
        run_to(3);
        check("serve_to_play", int'(o_state), 2);
        check("p1_step", int'(o_p1y), 223);
        check("p2_step", int'(o_p2y), 227);
        check("serve_centre_x", int'(o_ball_x), 320);
        run_to(4);
        check("first_serve_x", int'(o_ball_x), 321);
        check("first_serve_y", int'(o_ball_y), 266);
        run_to(300);
        check("p1_sat_top", int'(o_p1y), 80);
        check("p2_sat_bot", int'(o_p2y), 370);
        down1 = 1'b0;
        run_to(305);
        check("p1_both_hold", int'(o_p1y), 80);
        drop_run();
        check("idle_state", int'(o_state), 0);
        check("idle_p1y", int'(o_p1y), 225);
        check("idle_p2y", int'(o_p2y), 225);
        check("idle_scores", int'(o_p1score) + int'(o_p2score), 0);
        up1 = 1'b1; down1 = 1'b1; down2 = 1'b1;

        // rally: P2 returns, bottom wall, P1 misses, P1 returns, top wall
        i_run = 1'b1; down2 = 1'b0; tk = 0;
        run_to(41);
        check("p2_positioned", int'(o_p2y), 265);
        down2 = 1'b1;
        run_to(76);
        check("p2_hit_x", int'(o_ball_x), 393);
        check("p2_hit_y", int'(o_ball_y), 338);
        run_to(77);
        check("p2_hit_dx", int'(o_ball_x), 392);
        run_to(181);
        check("bot_wall_y", int'(o_ball_y), 443);
        run_to(182);
        check("bot_wall_dy", int'(o_ball_y), 442);
        run_to(222);
        check("p1_miss_state", int'(o_state), 3);
        check("p1_miss_score", int'(o_p2score), 0);
        run_to(223);
        check("p2_scored", int'(o_p2score), 1);
        check("point_to_serve", int'(o_state), 1);
        up1 = 1'b0;
        run_to(226);
        check("serve2_dx_neg", int'(o_ball_x), 319);
        check("serve2_dy_neg", int'(o_ball_y), 264);
        run_to(273);
        check("p1_positioned", int'(o_p1y), 175);
        up1 = 1'b1;
        run_to(298);
        check("p1_hit_x", int'(o_ball_x), 247);
        check("p1_hit_y", int'(o_ball_y), 192);
        run_to(299);
        check("p1_hit_dx", int'(o_ball_x), 248);
        run_to(402);
        check("top_pre_y", int'(o_ball_y), 88);
        run_to(403);
        check("top_wall_y", int'(o_ball_y), 87);
        check("top_wall_x", int'(o_ball_x), 352);
        run_to(404);
        check("top_wall_dy", int'(o_ball_y), 88);

        // P1 wins 11-0 with idle paddles
        drop_run();
        i_run = 1'b1; tk = 0;
        run_to(76);
        check("win_pt1_state", int'(o_state), 3);
        run_to(77);
        check("win_pt1_score", int'(o_p1score), 1);
        while (o_state !== 3'd4 && tk < 900) next_tick();
        check("win_tick", tk, 837);
        check("win_p1score", int'(o_p1score), 11);
        check("win_p2score", int'(o_p2score), 0);
        check("win_winner", int'(o_winner), 1);
        run_to(842);
        check("over_hold_state", int'(o_state), 4);
        check("over_hold_score", int'(o_p1score), 11);
        drop_run();
        check("over_idle_state", int'(o_state), 0);
        check("over_idle_score", int'(o_p1score), 0);
        check("over_idle_winner", int'(o_winner), 0);

        // asynchronous reset mid-rally while the strobe is high
        i_run = 1'b1; tk = 0;
        run_to(10);
        check("pre_reset_x", int'(o_ball_x), 327);
        for (int n = 0; n < 8 && o_tick !== 1'b1; n++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_tick", int'(o_tick), 0);
        check("mid_rst_state", int'(o_state), 0);
        check("mid_rst_x", int'(o_ball_x), 320);
        check("mid_rst_y", int'(o_ball_y), 265);
        @(negedge clk) rst_n = 1'b1;
        latency_check("tick_after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
